// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and
// the bit positions of the registered result flags.
package alu_pkg;

  // Legacy group: [3:2] picks the function, [1] the variant, [0] is the
  // arithmetic-right-shift select and is ignored elsewhere.
  localparam logic [4:0] OP_SHIFT = 5'b00000;
  localparam logic [4:0] OP_SRL   = 5'b00000;
  localparam logic [4:0] OP_SRA   = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_NOR   = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_ADD   = 5'b01100;
  localparam logic [4:0] OP_SUB   = 5'b01110;
  localparam logic [4:0] OP_MULU  = 5'b10000;
  localparam logic [4:0] OP_DIVU  = 5'b10001;

  localparam logic [1:0] GRP_SHIFT  = OP_SHIFT[3:2];
  localparam logic [1:0] GRP_ANDOR  = OP_AND[3:2];
  localparam logic [1:0] GRP_NORXOR = OP_NOR[3:2];
  localparam logic [1:0] GRP_ADDSUB = OP_ADD[3:2];

  localparam logic [1:0] MD_MULU = OP_MULU[1:0];
  localparam logic [1:0] MD_DIVU = OP_DIVU[1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DZ    = 3;
  localparam int NFLAGS     = 4;

  // Operations that go through the iterative datapath; divide by zero is
  // resolved immediately and never iterates.
  function automatic logic is_iterative(input logic [4:0] op, input logic divisor_zero);
    return op[4] && ((op[1:0] == MD_MULU) || ((op[1:0] == MD_DIVU) && !divisor_zero));
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step
// per clock over a shared 2*WIDTH accumulator and down-counter.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic             o_div,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH);

  logic               r_active;
  logic               r_div;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_part;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_fits;
  logic [2*WIDTH-1:0] w_acc_next;

  // Multiply: acc = {partial product, unconsumed multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_part = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_part - {1'b0, r_opnd};
    w_div_fits = !w_div_diff[WIDTH];
    if (r_div) begin
      w_acc_next = {(w_div_fits ? w_div_diff[WIDTH-1:0] : w_div_part[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_div_fits};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_div    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_div    <= i_div;
      r_cnt    <= CW'(WIDTH - 1);
      r_acc    <= {{WIDTH{1'b0}}, i_a};
      r_opnd   <= i_b;
    end else if (r_active) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end
    end
  end

  // The final step's result is presented combinationally so the owner can
  // capture it on the same edge the last iteration happens.
  assign o_done = r_active && (r_cnt == '0);
  assign o_div  = r_div;
  assign o_lo   = w_acc_next[WIDTH-1:0];
  assign o_hi   = w_acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle shift/logic/add/sub plus
// iterative unsigned multiply/divide, with registered results behind valid/ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [4:0]       opCode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shAmt,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] outHi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             divZero
);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  r_out_hi;
  logic [NFLAGS-1:0] r_flags;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_long;
  logic              w_start;

  logic [WIDTH-1:0]  w_b_eff;
  logic [WIDTH:0]    w_addsub;
  logic [WIDTH-1:0]  w_leg_lo;
  logic              w_leg_c;
  logic              w_leg_v;

  logic [WIDTH-1:0]  w_imm_lo;
  logic [WIDTH-1:0]  w_imm_hi;
  logic [NFLAGS-1:0] w_imm_flags;

  logic              w_md_done;
  logic              w_md_div;
  logic [WIDTH-1:0]  w_md_lo;
  logic [WIDTH-1:0]  w_md_hi;
  logic [NFLAGS-1:0] w_md_flags;

  // Legacy single-cycle datapath. SUB reuses the adder as in1 + ~in2 + 1,
  // so the adder carry-out is already the "not borrow" flag.
  always_comb begin
    w_b_eff  = opCode[1] ? ~in2 : in2;
    w_addsub = {1'b0, in1} + {1'b0, w_b_eff} + (WIDTH+1)'(opCode[1]);
    w_leg_lo = '0;
    w_leg_c  = 1'b0;
    w_leg_v  = 1'b0;
    case (opCode[3:2])
      GRP_SHIFT: begin
        if (opCode[1]) begin
          w_leg_lo = in1 << shAmt;
        end else if (opCode[0]) begin
          w_leg_lo = WIDTH'($signed(in1) >>> shAmt);
        end else begin
          w_leg_lo = in1 >> shAmt;
        end
      end
      GRP_ANDOR:  w_leg_lo = opCode[1] ? (in1 | in2) : (in1 & in2);
      GRP_NORXOR: w_leg_lo = opCode[1] ? (in1 ^ in2) : ~(in1 | in2);
      GRP_ADDSUB: begin
        w_leg_lo = w_addsub[WIDTH-1:0];
        w_leg_c  = w_addsub[WIDTH];
        w_leg_v  = (in1[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_addsub[WIDTH-1] != in1[WIDTH-1]);
      end
      default: w_leg_lo = '0;
    endcase
  end

  // Results that are known in the accept cycle: legacy ops, reserved
  // opcodes and divide by zero.
  always_comb begin
    w_imm_lo    = w_leg_lo;
    w_imm_hi    = '0;
    w_imm_flags = '0;
    w_imm_flags[FLAG_CARRY] = w_leg_c;
    w_imm_flags[FLAG_OVF]   = w_leg_v;
    if (opCode[4]) begin
      w_imm_lo    = '0;
      w_imm_flags = '0;
      if ((opCode[1:0] == MD_DIVU) && (in2 == '0)) begin
        w_imm_lo              = '1;
        w_imm_hi              = in1;
        w_imm_flags[FLAG_DZ]  = 1'b1;
      end
    end
    w_imm_flags[FLAG_ZERO] = (w_imm_lo == '0);
  end

  always_comb begin
    w_md_flags = '0;
    w_md_flags[FLAG_ZERO] = (w_md_lo == '0);
    w_md_flags[FLAG_OVF]  = !w_md_div && (w_md_hi != '0);
  end

  assign w_long     = is_iterative(opCode, in2 == '0);
  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && outReady);
  assign w_accept   = inValid && w_in_ready;
  assign w_start    = w_accept && w_long;

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_div   (opCode[0]),
    .i_a     (in1),
    .i_b     (in2),
    .o_done  (w_md_done),
    .o_div   (w_md_div),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next = w_long ? BUSY : DONE;
        end else if ((r_state == DONE) && outReady) begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (w_md_done) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result registers only move on a new immediate result or on the last
  // iteration; everywhere else they hold, which gives the stall stability.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_out_hi <= '0;
      r_flags  <= '0;
    end else if (w_accept && !w_long) begin
      r_out    <= w_imm_lo;
      r_out_hi <= w_imm_hi;
      r_flags  <= w_imm_flags;
    end else if ((r_state == BUSY) && w_md_done) begin
      r_out    <= w_md_lo;
      r_out_hi <= w_md_hi;
      r_flags  <= w_md_flags;
    end
  end

  assign inReady  = w_in_ready;
  assign outValid = (r_state == DONE);
  assign out      = r_out;
  assign outHi    = r_out_hi;
  assign zero     = r_flags[FLAG_ZERO];
  assign carry    = r_flags[FLAG_CARRY];
  assign ovf      = r_flags[FLAG_OVF];
  assign divZero  = r_flags[FLAG_DZ];

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor of the 32-bit datapath ALU. Keeps the single-cycle shift/logic/add/sub operation set, adds iterative unsigned multiply and divide, and registers results behind a valid/ready handshake, so the processor datapath can stall on long operations. Sits in the execute stage between the register-file read ports and the writeback mux.

## Interface
- `WIDTH`, 32: operand/result width; must be at least 4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `inValid`  in  1: operation offered.
- `inReady`  out  1: block can accept an operation this cycle.
- `opCode`  in  5: operation select.
- `in1`, `in2`  in  WIDTH: operands.
- `shAmt`  in  SHW: shift amount.
- `outValid`  out  1: result registers hold a valid result.
- `outReady`  in  1: consumer takes the result.
- `out`  out  WIDTH: primary result (low product / quotient / single-cycle result).
- `outHi`  out  WIDTH: high product / remainder; 0 for single-cycle ops.
- `zero`, `carry`, `ovf`, `divZero`  out  1 each: result flags.

## Operation
- Accept on `inValid & inReady`; operands and opcode are latched that cycle.
- `inReady = (state==IDLE) | (state==DONE & outReady)`.
- For `opCode[4]=0` (legacy group):
  - `opCode[3:2]` 00 selects shift: `[1]` 1=left, 0=right; `[0]` 1=arithmetic, applied to right shifts only.
  - 01 selects AND (`[1]`=0) or OR (`[1]`=1).
  - 10 selects NOR (`[1]`=0) or XOR (`[1]`=1).
  - 11 selects ADD (`[1]`=0) or SUB (`[1]`=1, in1−in2).
  - `opCode[0]` is ignored outside the shift group.
- For `opCode[4]=1`, `[1:0]` selects:
  - 00 MULU: {outHi,out} = in1×in2.
  - 01 DIVU: out=quotient, outHi=remainder.
  - 10, 11: reserved; produce 0 in one cycle.
- States:
  - IDLE: on accept, a legacy/reserved op → DONE; MULU/DIVU → BUSY, with the cycle counter loaded to WIDTH−1.
  - BUSY: one shift-add (MUL) or one restoring-subtract step (DIV) per cycle. At counter 0 → DONE.
  - DONE: `outValid=1`. Results stay stable until `outReady`. On `outReady`: with a new accept → DONE or BUSY as above; without one → IDLE.
- `carry`: carry-out for ADD, NOT borrow for SUB; 0 otherwise.
- `ovf`: two's-complement signed overflow for ADD/SUB; for MULU, set when outHi≠0; 0 otherwise.
- `zero = (out==0)` for every op.
- Divide by zero: out = all ones, outHi = in1, `divZero=1`, and the op completes in one cycle (IDLE→DONE, no BUSY).
- Shift amounts ≥ WIDTH cannot occur because of the SHW width.
- Reset: state IDLE; `out`, `outHi` and all flags 0; `outValid=0`; `inReady=1` from the first cycle after reset. Reset mid-BUSY abandons the operation; no result is produced.
- `inValid` while not ready is ignored; there is no queuing.

## Timing
- Single-cycle ops: `outValid` rises the cycle after accept (latency 1).
- MULU/DIVU: `outValid` rises WIDTH+1 cycles after accept (accept edge, then WIDTH iterations).
- Back-to-back single-cycle ops with `outReady` held high: one result per cycle.
- `outValid`, `out`, `outHi` and the flags are all registered; there is no combinational path from inputs to outputs except `outReady` → `inReady`.
- `inReady` is 0 throughout BUSY.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams: OP_SHIFT group, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_ADD, OP_SUB, OP_MULU, OP_DIVU;
  - state enum: IDLE, BUSY, DONE;
  - the flag bit ordering.
- Sub-module `alu_muldiv_iter` holds the iterative multiply/divide datapath: start/done interface, WIDTH-parameterised, 2×WIDTH accumulator, shared counter. The top level holds the combinational legacy datapath, the FSM and the output registers.

## Test plan
- ADD with WIDTH=32, in1=0x7FFFFFFF, in2=1 → next cycle: out=0x80000000, ovf=1, carry=0, zero=0, outHi=0.
- SUB in1=5, in2=5 → out=0, zero=1, carry=1. Arithmetic right shift of 0x80000000 by 4 → 0xF8000000. Logic right shift of the same → 0x08000000.
- MULU 0xFFFFFFFF×2 → after 33 cycles: out=0xFFFFFFFE, outHi=1, ovf=1. `inReady=0` for all cycles in between.
- DIVU 100/7 → out=14, outHi=2. DIVU 9/0 → one cycle later: out=0xFFFFFFFF, outHi=9, divZero=1.
- Backpressure: hold `outReady=0` for 5 cycles after an ADD → result and flags stable, `inReady=0`, and a concurrent `inValid` is ignored. Release, then 8 back-to-back ANDs → 8 consecutive results.
- Assert `rst` in the 10th BUSY cycle of a DIVU → next cycle: IDLE, `outValid=0`, out=0, `inReady=1`. A new ADD then completes normally.
